// File: rtl/mac_stream_driver_if.sv
// AXI-Stream bundle between the MAC stream driver and the MAC datapath:
// i/k/b operand streams toward the MAC and the o result stream back.
interface mac_stream_driver_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
);
  logic              i_TVALID;
  logic [DATA_W-1:0] i_TDATA;
  logic              i_TREADY;
  logic              k_TVALID;
  logic [DATA_W-1:0] k_TDATA;
  logic              k_TREADY;
  logic              b_TVALID;
  logic [DATA_W-1:0] b_TDATA;
  logic              b_TREADY;
  logic              o_TVALID;
  logic [ACC_W-1:0]  o_TDATA;
  logic              o_TREADY;

  modport master (
    output i_TVALID, i_TDATA, input i_TREADY,
    output k_TVALID, k_TDATA, input k_TREADY,
    output b_TVALID, b_TDATA, input b_TREADY,
    input  o_TVALID, o_TDATA, output o_TREADY
  );

  modport slave (
    input  i_TVALID, i_TDATA, output i_TREADY,
    input  k_TVALID, k_TDATA, output k_TREADY,
    input  b_TVALID, b_TDATA, output b_TREADY,
    output o_TVALID, o_TDATA, input o_TREADY
  );
endinterface

// File: rtl/mac_stream_driver.sv
// Streams a bias beat plus len input/kernel beat pairs from local buffers to the
// MAC unit, then waits for the single accumulated result on the o stream.
module mac_stream_driver #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [1:0]          wr_sel,
  input  logic [LEN_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ACC_W-1:0]    result,
  output logic                new_i,
  mac_stream_driver_if.master axis
);

  localparam int unsigned      IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StSend, StWaitO} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   i_idx_q, i_idx_d, k_idx_q, k_idx_d;
  logic               b_done_q, b_done_d;
  logic               i_pend_q, i_pend_d, k_pend_q, k_pend_d;
  logic               done_q, done_d, err_q, err_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]  ibuf_q [MAX_LEN];
  logic [DATA_W-1:0]  ibuf_d [MAX_LEN];
  logic [DATA_W-1:0]  kbuf_q [MAX_LEN];
  logic [DATA_W-1:0]  kbuf_d [MAX_LEN];
  logic [DATA_W-1:0]  bias_q, bias_d;

  logic               in_send, wr_ok;
  logic [IDX_W-1:0]   wr_ptr;
  logic               i_vld, k_vld, b_vld, i_hs, k_hs, b_hs;

  assign in_send = (state_q == StSend);
  assign wr_ptr  = wr_addr[IDX_W-1:0];
  assign wr_ok   = (state_q == StIdle) && wr_en && ((wr_sel == 2'd2) || (wr_addr < MaxLen));

  // A pending beat keeps VALID up regardless of stall; stall only blocks new assertions.
  assign i_vld = in_send && (i_idx_q < len_q) && (i_pend_q || !stall);
  assign k_vld = in_send && (k_idx_q < len_q) && (k_pend_q || !stall);
  assign b_vld = in_send && !b_done_q;
  assign i_hs  = i_vld && axis.i_TREADY;
  assign k_hs  = k_vld && axis.k_TREADY;
  assign b_hs  = b_vld && axis.b_TREADY;

  always_comb begin
    ibuf_d = ibuf_q;
    kbuf_d = kbuf_q;
    bias_d = bias_q;
    if (wr_ok) begin
      unique case (wr_sel)
        2'd0:    ibuf_d[wr_ptr] = wr_data;
        2'd1:    kbuf_d[wr_ptr] = wr_data;
        2'd2:    bias_d = wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    i_idx_d  = i_idx_q;
    k_idx_d  = k_idx_q;
    b_done_d = b_done_q;
    i_pend_d = 1'b0;
    k_pend_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((len != '0) && (len <= MaxLen)) begin
            len_d    = len;
            i_idx_d  = '0;
            k_idx_d  = '0;
            b_done_d = 1'b0;
            state_d  = StSend;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSend: begin
        i_pend_d = i_vld && !axis.i_TREADY;
        k_pend_d = k_vld && !axis.k_TREADY;
        if (i_hs) i_idx_d = i_idx_q + LEN_W'(1);
        if (k_hs) k_idx_d = k_idx_q + LEN_W'(1);
        if (b_hs) b_done_d = 1'b1;
        // Leave as soon as the final handshakes land, even in this same cycle.
        if (b_done_d && (i_idx_d == len_q) && (k_idx_d == len_q)) state_d = StWaitO;
      end
      StWaitO: begin
        if (axis.o_TVALID) begin
          result_d = axis.o_TDATA;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      i_idx_q  <= '0;
      k_idx_q  <= '0;
      b_done_q <= 1'b0;
      i_pend_q <= 1'b0;
      k_pend_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      i_idx_q  <= i_idx_d;
      k_idx_q  <= k_idx_d;
      b_done_q <= b_done_d;
      i_pend_q <= i_pend_d;
      k_pend_q <= k_pend_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Buffer and bias contents survive reset.
  always_ff @(posedge clk) begin
    ibuf_q <= ibuf_d;
    kbuf_q <= kbuf_d;
    bias_q <= bias_d;
  end

  assign busy   = (state_q != StIdle);
  assign new_i  = in_send;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

  assign axis.i_TVALID = i_vld;
  assign axis.i_TDATA  = ibuf_q[i_idx_q[IDX_W-1:0]];
  assign axis.k_TVALID = k_vld;
  assign axis.k_TDATA  = kbuf_q[k_idx_q[IDX_W-1:0]];
  assign axis.b_TVALID = b_vld;
  assign axis.b_TDATA  = bias_q;
  assign axis.o_TREADY = (state_q == StWaitO);

endmodule

// File: tb/tb_mac_stream_driver.sv
// Bench for mac_stream_driver: directed job table, rejected-start table, a mid-job
// reset sequence and randomized jobs checked against a beat-level reference model.
module tb_mac_stream_driver;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 32;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_sel = '0;
  logic [LEN_W-1:0]  wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              stall = 1'b0;
  logic              busy, done, err, new_i;
  logic [ACC_W-1:0]  result;

  always #5 clk = ~clk;

  mac_stream_driver_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) axis ();

  mac_stream_driver #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_sel (wr_sel),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start  (start),
    .len    (len),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result),
    .new_i  (new_i),
    .axis   (axis)
  );

  int nerr = 0;
  int nchk = 0;

  // Reference model state: what the buffers should hold.
  logic [DATA_W-1:0] mi [MAX_LEN];
  logic [DATA_W-1:0] mk [MAX_LEN];
  logic [DATA_W-1:0] mbias;

  typedef struct {
    int          jlen;
    int          mode;   // 0 free-flow, 1 random, 2 ready gap, 3 stall after 2 beats
    int          owait;
    bit          noise;  // start/writes/o_TVALID junk while busy, must be ignored
    logic [31:0] oval;
    logic [31:0] exp_res;
  } job_t;

  typedef struct {
    logic             st;
    logic [LEN_W-1:0] l;
    logic             exp_err;
  } rej_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input int addr, input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = LEN_W'(addr);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel == 2'd0 && addr < MAX_LEN) mi[addr] = d;
    if (sel == 2'd1 && addr < MAX_LEN) mk[addr] = d;
    if (sel == 2'd2) mbias = d;
  endtask

  // Starts a job from IDLE and follows it beat by beat until the result is taken.
  task automatic run_job(input string nm, input int jlen, input int mode, input int owait,
                         input bit noise, input logic [31:0] oval, input logic [31:0] exp_res);
    int ii = 0, kk = 0, wcnt = 0, scnt = 0, phase = 0, ib = 0, kb = 0, bb = 0, errs = 0;
    bit bdone = 0, ipend = 0, kpend = 0;
    bit e_iv, e_kv, e_bv, ir, kr, br, ov;
    start = 1'b1;
    len   = LEN_W'(jlen);
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && phase != 2; cyc++) begin
      case (mode)
        1: begin
          ir = ($urandom & 1) != 0;
          kr = ($urandom & 1) != 0;
          br = ($urandom & 1) != 0;
          stall = ($urandom % 4) == 0;
        end
        2: begin
          ir = !(cyc >= 2 && cyc <= 4);
          kr = ir;
          br = 1'b1;
          stall = 1'b0;
        end
        3: begin
          ir = 1'b1; kr = 1'b1; br = 1'b1;
          stall = (ii == 2) && (scnt < 2);
          if (stall) scnt++;
        end
        default: begin
          ir = 1'b1; kr = 1'b1; br = 1'b1; stall = 1'b0;
        end
      endcase
      ov = (phase == 1) && (wcnt >= owait);
      axis.i_TREADY = ir;
      axis.k_TREADY = kr;
      axis.b_TREADY = br;
      axis.o_TVALID = ov || (noise && phase == 0);
      axis.o_TDATA  = ov ? oval : $urandom;
      if (noise) begin
        start   = 1'b1;
        len     = LEN_W'(3);
        wr_en   = 1'b1;
        wr_sel  = 2'd2;
        wr_data = DATA_W'($urandom);
      end
      @(negedge clk);
      e_iv = (phase == 0) && (ii < jlen) && (ipend || !stall);
      e_kv = (phase == 0) && (kk < jlen) && (kpend || !stall);
      e_bv = (phase == 0) && !bdone;
      if (axis.i_TVALID !== e_iv) errs++;
      if (e_iv && axis.i_TDATA !== mi[ii]) errs++;
      if (axis.k_TVALID !== e_kv) errs++;
      if (e_kv && axis.k_TDATA !== mk[kk]) errs++;
      if (axis.b_TVALID !== e_bv) errs++;
      if (e_bv && axis.b_TDATA !== mbias) errs++;
      if (new_i !== (phase == 0)) errs++;
      if (busy !== 1'b1) errs++;
      if (axis.o_TREADY !== (phase == 1)) errs++;
      if (done !== 1'b0 || err !== 1'b0) errs++;
      if (axis.i_TVALID === 1'b1 && ir) ib++;
      if (axis.k_TVALID === 1'b1 && kr) kb++;
      if (axis.b_TVALID === 1'b1 && br) bb++;
      ipend = e_iv && !ir;
      kpend = e_kv && !kr;
      if (e_iv && ir) ii++;
      if (e_kv && kr) kk++;
      if (e_bv && br) bdone = 1;
      if (phase == 0) begin
        if (bdone && ii == jlen && kk == jlen) phase = 1;
      end else if (ov) begin
        phase = 2;
      end else begin
        wcnt++;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wr_en = 1'b0;
    stall = 1'b0;
    axis.o_TVALID = 1'b0;
    chk({nm, " completed"}, 64'(phase == 2), 64'd1);
    chk({nm, " cycle rules"}, 64'(errs), 64'd0);
    chk({nm, " i beats"}, 64'(ib), 64'(jlen));
    chk({nm, " k beats"}, 64'(kb), 64'(jlen));
    chk({nm, " b beats"}, 64'(bb), 64'd1);
    @(negedge clk);
    chk({nm, " done pulse"}, 64'(done), 64'd1);
    chk({nm, " result"}, 64'(result), 64'(exp_res));
    chk({nm, " busy after"}, 64'({busy, new_i}), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({nm, " done single"}, 64'(done), 64'd0);
    @(posedge clk);
    #1;
  endtask

  job_t jobs[7];
  rej_t rejs[4];

  initial begin
    jobs[0] = '{4, 0, 0, 0, 32'd80, 32'd80};
    jobs[1] = '{4, 2, 0, 0, 32'd81, 32'd81};
    jobs[2] = '{4, 3, 0, 0, 32'd82, 32'd82};
    jobs[3] = '{4, 0, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    jobs[4] = '{16, 0, 0, 1, 32'h12345678, 32'h12345678};
    jobs[5] = '{1, 0, 2, 1, 32'h0000CAFE, 32'h0000CAFE};
    jobs[6] = '{7, 1, 1, 0, 32'hA5A5A5A5, 32'hA5A5A5A5};
    rejs[0] = '{1'b1, 5'd0, 1'b1};
    rejs[1] = '{1'b1, 5'd17, 1'b1};
    rejs[2] = '{1'b1, 5'd31, 1'b1};
    rejs[3] = '{1'b0, 5'd5, 1'b0};

    axis.i_TREADY = 1'b0;
    axis.k_TREADY = 1'b0;
    axis.b_TREADY = 1'b0;
    axis.o_TVALID = 1'b0;
    axis.o_TDATA  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 64'({busy, done, err, new_i, axis.i_TVALID, axis.k_TVALID,
                              axis.b_TVALID, axis.o_TREADY}), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int a = 0; a < MAX_LEN; a++) begin
      wr(2'd0, a, DATA_W'(a + 1));
      wr(2'd1, a, DATA_W'(a + 5));
    end
    wr(2'd2, 0, 8'd10);

    for (int r = 0; r < 4; r++) begin
      start = rejs[r].st;
      len   = rejs[r].l;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk($sformatf("rej%0d err", r), 64'(err), 64'(rejs[r].exp_err));
      chk($sformatf("rej%0d idle", r), 64'({busy, new_i, axis.i_TVALID, axis.k_TVALID,
                                            axis.b_TVALID}), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("rej%0d err clear", r), 64'(err), 64'd0);
      @(posedge clk);
      #1;
    end

    for (int j = 0; j < 7; j++) begin
      if (j == 5) wr(2'd0, 16, 8'hEE);  // out-of-range address must be dropped
      run_job($sformatf("job%0d", j), jobs[j].jlen, jobs[j].mode, jobs[j].owait,
              jobs[j].noise, jobs[j].oval, jobs[j].exp_res);
    end

    // Reset during SEND after two beats, then a one-beat job from retained buffers.
    axis.i_TREADY = 1'b1;
    axis.k_TREADY = 1'b1;
    axis.b_TREADY = 1'b1;
    start = 1'b1;
    len   = LEN_W'(4);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre-reset beat", 64'({axis.i_TVALID, axis.i_TDATA}), 64'({1'b1, mi[2]}));
    #2;
    reset = 1'b0;
    #1;
    chk("async reset outputs", 64'({busy, done, err, new_i, axis.i_TVALID, axis.k_TVALID,
                                    axis.b_TVALID, axis.o_TREADY}), 64'd0);
    chk("async reset result", 64'(result), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_job("post_reset", 1, 0, 0, 0, 32'h00000042, 32'h00000042);

    for (int r = 0; r < 20; r++) begin
      int n;
      int jl;
      logic [31:0] ov;
      n = $urandom % 4;
      for (int w = 0; w < n; w++) wr(2'($urandom % 4), $urandom % 18, DATA_W'($urandom));
      jl = 1 + ($urandom % MAX_LEN);
      ov = $urandom;
      run_job($sformatf("rnd%0d", r), jl, 1, $urandom % 4, ($urandom & 1) != 0, ov, ov);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
